// File: rtl/sprdma.sv
// Sprite (OAM) DMA: a CPU write to TRIGGER_ADDR stalls the CPU and copies
// page {data,00..FF} to OAMDATA_ADDR with alternating read/write cycles.
// Ports: clk, rst_n (async, active-low), cpu_ce end-of-CPU-cycle strobe,
//   cpu_addr_in/cpu_wr_in/cpu_dout_in snooped CPU bus, cpu_rdy stall,
//   bus_sel/bus_addr/bus_wr/bus_dout DMA master bus, bus_din read data,
//   done one-clk completion pulse.
// Optional macro SPRDMA_ODD_ALIGN_EN: extra align cycle on odd triggers.
module sprdma #(
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_wr_in,
  input  logic [7:0]  cpu_dout_in,
  output logic        cpu_rdy,
  output logic        bus_sel,
  output logic [15:0] bus_addr,
  output logic        bus_wr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN0,
    S_ALIGN1,
    S_READ,
    S_WRITE,
    S_FIN
  } state_e;

  state_e      state_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  data_q;
  logic        cpu_rdy_q;
  logic        bus_sel_q;
  logic [15:0] bus_addr_q;
  logic        bus_wr_q;
  logic        done_q;
  logic        trig;

`ifdef SPRDMA_ODD_ALIGN_EN
  logic        odd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odd_q <= 1'b0;
    end else if (cpu_ce) begin
      odd_q <= ~odd_q;
    end
  end
`endif

  assign trig = cpu_wr_in && (cpu_addr_in == TRIGGER_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      data_q     <= 8'h00;
      cpu_rdy_q  <= 1'b1;
      bus_sel_q  <= 1'b0;
      bus_addr_q <= 16'h0000;
      bus_wr_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cpu_ce) begin
        unique case (state_q)
          S_IDLE: begin
            if (trig) begin
              page_q     <= cpu_dout_in;
              idx_q      <= 8'h00;
              cpu_rdy_q  <= 1'b0;
              bus_sel_q  <= 1'b1;
              bus_wr_q   <= 1'b0;
              bus_addr_q <= {cpu_dout_in, 8'h00};
              state_q    <= S_ALIGN0;
            end
          end
          S_ALIGN0: begin
`ifdef SPRDMA_ODD_ALIGN_EN
            // odd_q has toggled once since the trigger edge, so a
            // low value here means the trigger cycle was odd.
            if (!odd_q) begin
              state_q <= S_ALIGN1;
            end else begin
              state_q <= S_READ;
            end
`else
            state_q <= S_READ;
`endif
          end
          S_ALIGN1: begin
            state_q <= S_READ;
          end
          S_READ: begin
            data_q     <= bus_din;
            bus_addr_q <= OAMDATA_ADDR;
            bus_wr_q   <= 1'b1;
            state_q    <= S_WRITE;
          end
          S_WRITE: begin
            bus_wr_q <= 1'b0;
            if (idx_q == 8'hFF) begin
              // Hand the bus back now so FIN cannot issue a stray access.
              bus_sel_q <= 1'b0;
              state_q   <= S_FIN;
            end else begin
              idx_q      <= idx_q + 8'd1;
              bus_addr_q <= {page_q, idx_q + 8'd1};
              state_q    <= S_READ;
            end
          end
          S_FIN: begin
            bus_sel_q <= 1'b0;
            bus_wr_q  <= 1'b0;
            cpu_rdy_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign cpu_rdy  = cpu_rdy_q;
  assign bus_sel  = bus_sel_q;
  assign bus_addr = bus_addr_q;
  assign bus_wr   = bus_wr_q;
  assign bus_dout = data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sprdma.sv
// Randomised bench for sprdma: memory model, bus monitor and
// transaction-level expectations built from the page-copy rules.
module tb_sprdma;

`ifdef SPRDMA_ODD_ALIGN_EN
  localparam int ODD_EN = 1;
`else
  localparam int ODD_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_ce = 1'b0;
  logic [15:0] cpu_addr_in = 16'h0000;
  logic        cpu_wr_in = 1'b0;
  logic [7:0]  cpu_dout_in = 8'h00;
  logic [7:0]  bus_din = 8'h00;
  logic        cpu_rdy;
  logic        bus_sel;
  logic [15:0] bus_addr;
  logic        bus_wr;
  logic [7:0]  bus_dout;
  logic        done;

  sprdma dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_ce      (cpu_ce),
    .cpu_addr_in (cpu_addr_in),
    .cpu_wr_in   (cpu_wr_in),
    .cpu_dout_in (cpu_dout_in),
    .cpu_rdy     (cpu_rdy),
    .bus_sel     (bus_sel),
    .bus_addr    (bus_addr),
    .bus_wr      (bus_wr),
    .bus_dout    (bus_dout),
    .bus_din     (bus_din),
    .done        (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];

  always @(posedge clk) bus_din <= mem[bus_addr];

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         wr_q[$];
  logic [15:0] rd_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          stall_cnt = 0;
  int          done_cnt = 0;
  int          cyc_cnt = 0;
  int          viol = 0;
  int          sel_clk = 0;
  int          rdylow_clk = 0;
  bit          prev_v = 0;
  logic        prev_ce = 0;
  logic [26:0] prev_out = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: sampled on the falling edge, so cpu_ce seen here is the
  // value present at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc_cnt = 0;
      prev_v = 0;
    end else begin
      if (prev_v && !prev_ce &&
          {bus_sel, bus_wr, bus_addr, bus_dout, cpu_rdy} != prev_out)
        viol++;
      prev_v = 1;
      prev_ce = cpu_ce;
      prev_out = {bus_sel, bus_wr, bus_addr, bus_dout, cpu_rdy};
      if (bus_sel) sel_clk++;
      if (!cpu_rdy) rdylow_clk++;
      if (done) done_cnt++;
      if (cpu_ce) begin
        cyc_cnt++;
        if (!cpu_rdy) stall_cnt++;
        if (bus_sel && bus_wr) wr_q.push_back('{bus_addr, bus_dout});
        if (bus_sel && !bus_wr) rd_q.push_back(bus_addr);
      end
    end
  end

  // One CPU cycle of 2..6 clk, cpu_ce on its last clk.
  task automatic cpu_cycle(input logic [15:0] a, input logic w,
                           input logic [7:0] d);
    int g;
    g = int'($urandom_range(2, 6));
    cpu_addr_in = a;
    cpu_wr_in = w;
    cpu_dout_in = d;
    for (int i = 0; i < g; i++) begin
      cpu_ce = (i == g - 1);
      @(posedge clk);
      #1;
    end
    cpu_ce = 1'b0;
    cpu_wr_in = 1'b0;
  endtask

  task automatic run_dma(input logic [7:0] pg, input int want_odd,
                         input int abort_at);
    int bad;
    int nrd;
    int oop;
    wr_q.delete();
    rd_q.delete();
    stall_cnt = 0;
    done_cnt = 0;
    viol = 0;
    if ((cyc_cnt % 2) != want_odd) cpu_cycle(16'h8000, 1'b0, 8'h00);
    cpu_cycle(16'h4014, 1'b1, pg);
    for (int i = 0; i < 700 && done_cnt == 0; i++) begin
      cpu_cycle(16'h8000, 1'b0, 8'h00);
      if (abort_at > 0 && wr_q.size() >= abort_at) return;
    end
    cpu_cycle(16'h8000, 1'b0, 8'h00);
    cpu_cycle(16'h8000, 1'b0, 8'h00);
    check("done_pulses", done_cnt, 1);
    check("stall_len", stall_cnt, 514 + ODD_EN * want_odd);
    check("n_writes", wr_q.size(), 256);
    bad = 0;
    for (int n = 0; n < 256 && n < wr_q.size(); n++) begin
      if (wr_q[n].a != 16'h2004 || wr_q[n].d != mem[{pg, 8'(n)}]) bad++;
    end
    check("write_seq", bad, 0);
    nrd = 257 + ODD_EN * want_odd;
    check("n_reads", rd_q.size(), nrd);
    bad = 0;
    oop = 0;
    foreach (rd_q[k]) begin
      if (rd_q[k][15:8] != pg) oop++;
      if (k >= rd_q.size() - 256 && rd_q[k] != {pg, 8'(k + 256 - rd_q.size())})
        bad++;
    end
    check("read_seq", bad, 0);
    check("read_out_of_page", oop, 0);
    if (rd_q.size() > 0)
      check("last_read", 32'(rd_q[rd_q.size() - 1]), 32'({pg, 8'hFF}));
    check("stable_between_ce", viol, 0);
    check("rdy_after", 32'(cpu_rdy), 1);
    check("sel_after", 32'(bus_sel), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, 32'(cpu_rdy), 1);
    check({tag, "_sel"}, 32'(bus_sel), 0);
    check({tag, "_addr"}, 32'(bus_addr), 0);
    check({tag, "_wr"}, 32'(bus_wr), 0);
    check({tag, "_dout"}, 32'(bus_dout), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 256; n++) mem[16'h0200 + n] = 8'(n) ^ 8'hA5;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (3) cpu_cycle(16'h8000, 1'b0, 8'h00);

    run_dma(8'h02, 0, 0);
    run_dma(8'h02, 1, 0);
    run_dma(8'hC0, 0, 0);
    run_dma(8'h5A, 1, 0);

    run_dma(8'h01, 0, 64);
    check("abort_point", wr_q.size(), 64);
    check("abort_sel_busy", 32'(bus_sel), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cpu_cycle(16'h8000, 1'b0, 8'h00);
    run_dma(8'h03, 0, 0);

    sel_clk = 0;
    rdylow_clk = 0;
    done_cnt = 0;
    cpu_cycle(16'h4015, 1'b1, 8'h02);
    cpu_cycle(16'h4014, 1'b0, 8'h02);
    cpu_addr_in = 16'h4014;
    cpu_wr_in = 1'b1;
    cpu_dout_in = 8'h02;
    repeat (3) @(posedge clk);
    #1;
    cpu_wr_in = 1'b0;
    repeat (3) cpu_cycle(16'h8000, 1'b0, 8'h00);
    check("neg_sel", sel_clk, 0);
    check("neg_rdy", rdylow_clk, 0);
    check("neg_done", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprdma.md
# sprdma

Sprite (OAM) DMA engine placed directly upstream of the CPU memory controller, as a second bus master beside the CPU core. It detects a CPU write to 0x4014, stalls the CPU, and copies the 256-byte page `{data, 8'h00}`–`{data, 8'hFF}` to the PPU OAM data register at 0x2004. It uses alternating read/write CPU cycles on the same address/data bus the CPU drives. A top-level mux, steered by `bus_sel`, chooses which master drives the memory controller.

## Interface
Parameters:
- `OAMDATA_ADDR`, default 16'h2004: destination address of every DMA write.
- `TRIGGER_ADDR`, default 16'h4014: CPU write address that starts a transfer.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `cpu_ce`  in  1  one-`clk` pulse marking the end of each CPU cycle. Pulses are at least 2 `clk` apart.
- `cpu_addr_in`  in  16  CPU address, snooped.
- `cpu_wr_in`  in  1  CPU write enable, snooped.
- `cpu_dout_in`  in  8  CPU write data, snooped.
- `cpu_rdy`  out  1  0 stalls the CPU core.
- `bus_sel`  out  1  1 means the DMA owns the memory-controller bus.
- `bus_addr`  out  16  DMA bus address.
- `bus_wr`  out  1  DMA bus write enable.
- `bus_dout`  out  8  DMA write data.
- `bus_din`  in  8  memory-controller read data. The source RAM is synchronous; data is valid from the 2nd `clk` after the address changes.
- `done`  out  1  one-`clk` pulse when a transfer completes.

## Operation
- Registers:
  - `page[7:0]`
  - `idx[7:0]`
  - `data[7:0]`
  - `odd`: CPU-cycle parity. Toggles on every `cpu_ce`, and is 0 after reset.
  - `state`
- States: IDLE, ALIGN0, ALIGN1, READ, WRITE, FIN. All transitions, and all bus output updates, happen only on `clk` edges where `cpu_ce`=1.
- IDLE:
  - Trigger condition: `cpu_wr_in`=1 and `cpu_addr_in`==`TRIGGER_ADDR`.
  - On trigger: `page`<=`cpu_dout_in`, `idx`<=0, `cpu_rdy`<=0, go to ALIGN0.
  - Otherwise the block stays in IDLE with `bus_sel`=0.
- ALIGN0: dummy cycle with `bus_sel`=1, `bus_wr`=0, `bus_addr`=`{page, 8'h00}`. The next state is ALIGN1 if the trigger happened on an odd CPU cycle, otherwise READ (see Configuration).
- ALIGN1: one extra dummy cycle, same outputs as ALIGN0, then READ.
- READ: `bus_addr`=`{page, idx}`, `bus_wr`=0. On the `cpu_ce` that ends the cycle, `data`<=`bus_din`, then go to WRITE.
- WRITE: `bus_addr`=`OAMDATA_ADDR`, `bus_wr`=1, `bus_dout`=`data`. At the end of the cycle:
  - if `idx`==8'hFF, go to FIN;
  - else `idx`<=`idx`+1 and go to READ.
- `idx` is 8-bit and is never wrapped by increment; the FIN check prevents wrap-around.
- FIN: `bus_sel`<=0, `bus_wr`<=0, `cpu_rdy`<=1, `done` pulses for one `clk`, go to IDLE.
- A trigger write issued while not in IDLE is ignored. The CPU is stalled then, so this only arises from misuse.
- `bus_addr` bits come only from `page` and `idx`, so no address carry leaves the page.

## Timing
- Reset values, set immediately while `rst_n`=0:
  - `cpu_rdy`=1
  - `bus_sel`=0
  - `bus_addr`=16'h0000
  - `bus_wr`=0
  - `bus_dout`=8'h00
  - `done`=0
  - `state`=IDLE, `odd`=0, `page`=`idx`=`data`=0
- Reset mid-transfer aborts the transfer, and the bus returns to the CPU. The next trigger restarts at `idx`=0.
- `cpu_rdy` falls on the trigger `cpu_ce` edge, so the CPU instruction after the STA is stalled.
- Stall length, counted in CPU cycles from ALIGN0 through the final WRITE:
  - 513 for an even trigger cycle;
  - 514 for an odd trigger cycle;
  - FIN adds 1 more.
- All bus outputs are registered and stable for an entire CPU cycle. `bus_din` is sampled only at the end of READ, which is at least 2 `clk` after the address is presented.

## Configuration
- `SPRDMA_ODD_ALIGN_EN`
  - Defined: ALIGN1 is inserted when `odd`=1 at the trigger edge, matching the NES 513/514-cycle behaviour.
  - Undefined: ALIGN1 is never entered, so every transfer stalls exactly 513 cycles. The `odd` register and its logic are compiled out.

## Test plan
- Even-parity trigger, page 0x02, RAM[0x0200+n]=n^0xA5:
  - 256 writes to 0x2004 with data n^0xA5 in order, and no other bus writes;
  - `cpu_rdy` low for 514 `cpu_ce` (513 + FIN);
  - one `done` pulse.
- Same trigger on an odd cycle with the macro defined: one extra dummy cycle, and `cpu_rdy` low for 515 `cpu_ce`. With the macro undefined: 514.
- Page 0xC0: reads sweep 0xC000–0xC0FF from PRG-ROM HI, and the last read address is 0xC0FF with no 0xC100 access.
- `rst_n` pulsed low mid-transfer at `idx`=0x40: all outputs take their reset values asynchronously. A new trigger with page 0x03 transfers 0x0300–0x03FF from index 0.
- `cpu_ce` spacing randomised over 2–6 `clk`: identical write data sequence, and bus outputs change only on `cpu_ce` edges.
- CPU write to 0x4015, a CPU read of 0x4014, and a write to 0x4014 with `cpu_ce`=0: no transfer, `bus_sel` stays 0, and `cpu_rdy` stays 1.
